// File: rtl/system_workers_cpu_mult_pkg.sv
// Shared definitions for the sequential lane-based multiplier.
// Holds the op encodings, the FSM state type and small operand-sign helpers.
package system_workers_cpu_mult_pkg;

  localparam int unsigned OP_W = 2;

  // 00 returns the low half; the X variants return the high half of the product.
  typedef enum logic [OP_W-1:0] {
    OP_MUL    = 2'b00,
    OP_MULXUU = 2'b01,
    OP_MULXSU = 2'b10,
    OP_MULXSS = 2'b11
  } mult_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } mult_state_e;

  // src1 is read as two's complement for MULXSU and MULXSS.
  function automatic logic op_src1_signed(input logic [OP_W-1:0] op);
    return (op == OP_MULXSU) || (op == OP_MULXSS);
  endfunction

  // src2 is read as two's complement only for MULXSS.
  function automatic logic op_src2_signed(input logic [OP_W-1:0] op);
    return (op == OP_MULXSS);
  endfunction

endpackage

// File: rtl/system_workers_cpu_mult_lane.sv
// Single unsigned LANE_W x LANE_W multiplier, purely combinational.
// Ports:
//   a_i, b_i : LANE_W-bit unsigned operands
//   p_o      : 2*LANE_W-bit unsigned product
module system_workers_cpu_mult_lane #(
  parameter int unsigned LANE_W = 16
) (
  input  logic [LANE_W-1:0]   a_i,
  input  logic [LANE_W-1:0]   b_i,
  output logic [2*LANE_W-1:0] p_o
);

  localparam int unsigned PROD_W = 2 * LANE_W;

  assign p_o = PROD_W'(a_i) * PROD_W'(b_i);

endmodule

// File: rtl/system_workers_cpu_mult_seq.sv
// Sequential multiplier built from one LANE_W x LANE_W lane multiplier.
// Operands are split into K = DATA_W/LANE_W lanes; one lane pair is multiplied
// per CALC cycle and accumulated into a 2*DATA_W sum of magnitudes. FIX applies
// the product sign and then selects the requested half into the result.
// Optional feature: define MULT_SEQ_EARLY_OUT_EN to leave CALC after pair (0,0)
// when both magnitudes fit in lane 0.
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   in_valid, in_ready : request handshake (in_ready high only in IDLE)
//   src1, src2, op     : operands and operation (MUL / MULXUU / MULXSU / MULXSS)
//   flush              : abort any operation in flight
//   out_valid, out_ready : result handshake
//   result             : selected half of the product
module system_workers_cpu_mult_seq
  import system_workers_cpu_mult_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LANE_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  input  logic [OP_W-1:0]   op,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result
);

  localparam int unsigned K      = DATA_W / LANE_W;
  localparam int unsigned IDX_W  = (K > 1) ? $clog2(K) : 1;
  localparam int unsigned ACC_W  = 2 * DATA_W;
  localparam int unsigned PROD_W = 2 * LANE_W;

  mult_state_e       state_q,     state_d;
  logic [DATA_W-1:0] mag1_q,      mag1_d;
  logic [DATA_W-1:0] mag2_q,      mag2_d;
  logic              neg_q,       neg_d;
  logic [OP_W-1:0]   op_q,        op_d;
  logic [ACC_W-1:0]  acc_q,       acc_d;
  logic [IDX_W-1:0]  lane_i_q,    lane_i_d;
  logic [IDX_W-1:0]  lane_j_q,    lane_j_d;
  logic              fix_ph_q,    fix_ph_d;
  logic              out_valid_q, out_valid_d;
  logic              in_ready_q,  in_ready_d;
  logic [DATA_W-1:0] result_q,    result_d;

  logic [LANE_W-1:0] lane_a_c;
  logic [LANE_W-1:0] lane_b_c;
  logic [PROD_W-1:0] lane_p_c;
  logic [ACC_W-1:0]  lane_term_c;
  logic              last_pair_c;
  logic              early_out_c;
  logic              s1_neg_c;
  logic              s2_neg_c;

  // Current lane pair: lane i of src1 magnitude times lane j of src2 magnitude.
  assign lane_a_c = LANE_W'(mag1_q >> (LANE_W * 32'(lane_i_q)));
  assign lane_b_c = LANE_W'(mag2_q >> (LANE_W * 32'(lane_j_q)));

  system_workers_cpu_mult_lane #(
    .LANE_W (LANE_W)
  ) u_lane (
    .a_i (lane_a_c),
    .b_i (lane_b_c),
    .p_o (lane_p_c)
  );

  // Partial product weighted by its lane position (i+j)*LANE_W.
  assign lane_term_c = ACC_W'(lane_p_c) << (LANE_W * (32'(lane_i_q) + 32'(lane_j_q)));

  assign last_pair_c = (lane_i_q == IDX_W'(K - 1)) && (lane_j_q == IDX_W'(K - 1));

`ifdef MULT_SEQ_EARLY_OUT_EN
  // Both magnitudes live entirely in lane 0: pair (0,0) is the whole product.
  assign early_out_c = ((mag1_q >> LANE_W) == '0) && ((mag2_q >> LANE_W) == '0);
`else
  assign early_out_c = 1'b0;
`endif

  assign s1_neg_c = op_src1_signed(op) && src1[DATA_W-1];
  assign s2_neg_c = op_src2_signed(op) && src2[DATA_W-1];

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    mag1_d      = mag1_q;
    mag2_d      = mag2_q;
    neg_d       = neg_q;
    op_d        = op_q;
    acc_d       = acc_q;
    lane_i_d    = lane_i_q;
    lane_j_d    = lane_j_q;
    fix_ph_d    = fix_ph_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          // Magnitude of 0x80..0 negates to itself, which is correct read unsigned.
          mag1_d   = s1_neg_c ? (DATA_W'(0) - src1) : src1;
          mag2_d   = s2_neg_c ? (DATA_W'(0) - src2) : src2;
          neg_d    = s1_neg_c ^ s2_neg_c;
          op_d     = op;
          acc_d    = '0;
          lane_i_d = '0;
          lane_j_d = '0;
          fix_ph_d = 1'b0;
          state_d  = ST_CALC;
        end
      end

      ST_CALC: begin
        acc_d = acc_q + lane_term_c;
        if (last_pair_c || (early_out_c && (lane_i_q == '0) && (lane_j_q == '0))) begin
          lane_i_d = '0;
          lane_j_d = '0;
          state_d  = ST_FIX;
        end else if (lane_j_q == IDX_W'(K - 1)) begin
          lane_j_d = '0;
          lane_i_d = lane_i_q + IDX_W'(1);
        end else begin
          lane_j_d = lane_j_q + IDX_W'(1);
        end
      end

      ST_FIX: begin
        // Phase 0 applies the sign in place; phase 1 selects the half.
        if (!fix_ph_q) begin
          if (neg_q) begin
            acc_d = ACC_W'(0) - acc_q;
          end
          fix_ph_d = 1'b1;
        end else begin
          result_d    = (op_q == OP_MUL) ? acc_q[DATA_W-1:0] : acc_q[ACC_W-1:DATA_W];
          out_valid_d = 1'b1;
          fix_ph_d    = 1'b0;
          state_d     = ST_DONE;
        end
      end

      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Flush wins over everything in this block, including an IDLE accept.
    if (flush) begin
      state_d     = ST_IDLE;
      out_valid_d = 1'b0;
      result_d    = '0;
      acc_d       = '0;
      lane_i_d    = '0;
      lane_j_d    = '0;
      fix_ph_d    = 1'b0;
    end

    in_ready_d = (state_d == ST_IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      mag1_q      <= '0;
      mag2_q      <= '0;
      neg_q       <= 1'b0;
      op_q        <= '0;
      acc_q       <= '0;
      lane_i_q    <= '0;
      lane_j_q    <= '0;
      fix_ph_q    <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      mag1_q      <= mag1_d;
      mag2_q      <= mag2_d;
      neg_q       <= neg_d;
      op_q        <= op_d;
      acc_q       <= acc_d;
      lane_i_q    <= lane_i_d;
      lane_j_q    <= lane_j_d;
      fix_ph_q    <= fix_ph_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      result_q    <= result_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;

endmodule
